input_devices: RTL and testbench

Read-side counterpart of the output device block in the emulator's sequential I/O. It samples two 32-bit external input buses through a synchronizer, tracks per-device "new data" and "overrun" flags, and serves processor reads on the same 16-bit address map the output path uses for writes. Read data is registered: one-cycle latency from sampled read request to `value`.

---
 rtl/input_devices_pkg.sv | 35 +++
 rtl/input_devices_sync_chain.sv | 39 +++
 rtl/input_devices.sv | 115 +++++++++++
 tb/tb_input_devices.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/input_devices_pkg.sv
// Shared constants and helpers for the sequential input device block:
// the read address map, STATUS bit layout and a STATUS word builder.
package input_devices_pkg;

  localparam int NUM_DEV = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_DEV0   = 16'd0;
  localparam logic [ADDR_W-1:0] ADDR_DEV1   = 16'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 16'd2;

  localparam int ST_PEND0 = 0;
  localparam int ST_PEND1 = 1;
  localparam int ST_OVR0  = 2;
  localparam int ST_OVR1  = 3;

  // Per-device flag state, one bit per device in each field.
  typedef struct packed {
    logic [NUM_DEV-1:0] ovr;
    logic [NUM_DEV-1:0] pend;
  } flags_t;

  // Pack the flag state into the 32-bit STATUS read word.
  function automatic logic [DATA_W-1:0] status_word(input flags_t f);
    logic [DATA_W-1:0] w;
    w           = '0;
    w[ST_PEND0] = f.pend[0];
    w[ST_PEND1] = f.pend[1];
    w[ST_OVR0]  = f.ovr[0];
    w[ST_OVR1]  = f.ovr[1];
    return w;
  endfunction

endpackage

// File: rtl/input_devices_sync_chain.sv
// Multi-flop synchronizer for one external input bus. The last stage
// is the value the rest of the block treats as the device's sampled data.
module sync_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Shift: stage 0 takes the raw bus, each later stage takes its predecessor.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Synchronous clear of every stage, otherwise advance the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/input_devices.sv
// Read side of the emulator's sequential I/O: two synchronized input
// buses with new-data (pend) and overrun (ovr) flags, served on the same
// 16-bit address map the output path uses for writes.
//
// Read protocol: is_read is a single-cycle strobe with no back-pressure.
// Whenever is_read is high at a rising edge the request is accepted and
// value carries the result right after that edge; consecutive strobes are
// consecutive reads. With is_read low, value holds and no flag is touched.
module input_devices
  import input_devices_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] device0_values,
  input  logic [DATA_W-1:0] device1_values,
  input  logic [ADDR_W-1:0] address,
  input  logic              is_read,
  output logic [DATA_W-1:0] value
);

  // Warm-up spans the cycles in which the synchronizers refill from 0.
  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

  logic [DATA_W-1:0]  sync   [NUM_DEV];
  logic [DATA_W-1:0]  prev_q [NUM_DEV];
  logic [DATA_W-1:0]  prev_d [NUM_DEV];
  flags_t             flags_q, flags_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [DATA_W-1:0]  value_q, value_d;

  logic               warm_busy;
  logic [NUM_DEV-1:0] change;
  logic [NUM_DEV-1:0] rd_dev;
  logic               rd_status;
  logic [DATA_W-1:0]  rd_data;

  sync_chain #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync0 (
    .clk   (clk),
    .reset (reset),
    .d     (device0_values),
    .q     (sync[0])
  );

  sync_chain #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync1 (
    .clk   (clk),
    .reset (reset),
    .d     (device1_values),
    .q     (sync[1])
  );

  // Next-state logic: warm-up countdown, change detect, flags, read mux.
  always_comb begin
    warm_busy = (warm_q != '0);
    warm_d    = warm_busy ? (warm_q - WARM_W'(1)) : warm_q;

    rd_dev[0] = is_read && (address == ADDR_DEV0);
    rd_dev[1] = is_read && (address == ADDR_DEV1);
    rd_status = is_read && (address == ADDR_STATUS);

    flags_d = flags_q;
    for (int i = 0; i < NUM_DEV; i++) begin
      prev_d[i] = sync[i];
      change[i] = !warm_busy && (sync[i] != prev_q[i]);

      // New data beats a same-cycle read of that device.
      if (change[i]) begin
        flags_d.pend[i] = 1'b1;
      end else if (rd_dev[i]) begin
        flags_d.pend[i] = 1'b0;
      end

      // A change only overruns if the pending data is not being read now;
      // a fresh overrun beats a same-cycle STATUS clear.
      if (change[i] && flags_q.pend[i] && !rd_dev[i]) begin
        flags_d.ovr[i] = 1'b1;
      end else if (rd_status) begin
        flags_d.ovr[i] = 1'b0;
      end
    end

    case (address)
      ADDR_DEV0:   rd_data = sync[0];
      ADDR_DEV1:   rd_data = sync[1];
      ADDR_STATUS: rd_data = status_word(flags_q);
      default:     rd_data = '0;
    endcase

    value_d = is_read ? rd_data : value_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        prev_q[i] <= '0;
      end
      flags_q <= '0;
      warm_q  <= WARM_LOAD;
      value_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DEV; i++) begin
        prev_q[i] <= prev_d[i];
      end
      flags_q <= flags_d;
      warm_q  <= warm_d;
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: tb/tb_input_devices.sv
// Bench for input_devices: reads are driven by a task that pushes the
// expected data into a queue; a monitor pops and compares after each
// accepted read. Address decode runs from a table, corner cases by hand.
module tb_input_devices;
  import input_devices_pkg::*;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d0, d1;
  logic [15:0] address;
  logic        is_read;
  logic [31:0] value;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] a0, a1;

  input_devices #(.SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .reset          (reset),
    .device0_values (d0),
    .device1_values (d1),
    .address        (address),
    .is_read        (is_read),
    .value          (value)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One read strobe; back-to-back calls give reads on consecutive edges.
  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    address = a;
    is_read = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    is_read = 1'b0;
  endtask

  // Scoreboard: every accepted read produces one value to compare.
  always @(posedge clk) begin
    if (!reset && is_read) begin
      logic [31:0] e;
      string       nm;
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", value);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, value, e);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    d0      = 32'hFFFF_FFFF;
    d1      = 32'hFFFF_FFFF;
    address = '0;
    is_read = 1'b0;

    // Reset held two cycles with buses all ones.
    @(negedge clk);
    check("reset_value", value, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    rd(ADDR_DEV0,   32'hFFFF_FFFF, "warmup_read");
    rd(ADDR_STATUS, 32'h0,         "reset_status");
    tick(2);
    rd(ADDR_STATUS, 32'h0,         "reset_status2");
    rd(ADDR_DEV1,   32'hFFFF_FFFF, "reset_dev1");

    // Capture on device 0, including the edge just before pend rises.
    d0 = 32'hE5F8_4AB1;
    tick(SS);
    rd(ADDR_STATUS, 32'h0,         "pend_early");
    rd(ADDR_STATUS, 32'h1,         "capture_status");
    rd(ADDR_DEV0,   32'hE5F8_4AB1, "capture_data");
    rd(ADDR_STATUS, 32'h0,         "capture_clear");

    // Overrun on device 1: two changes without a read.
    d1 = 32'h5C8C_6A01;
    tick(1);
    d1 = 32'h0000_0001;
    tick(SS + 1);
    rd(ADDR_STATUS, 32'hA,         "ovr_status");
    rd(ADDR_STATUS, 32'h2,         "ovr_cleared");
    rd(ADDR_DEV1,   32'h0000_0001, "ovr_data");
    rd(ADDR_STATUS, 32'h0,         "ovr_all_clear");

    // Read of device 0 on the edge where a second change sets pend0.
    d0 = 32'h0F0F_1234;
    tick(SS + 1);
    d0 = 32'h7A7A_0001;
    tick(SS);
    rd(ADDR_DEV0,   32'h7A7A_0001, "simul_data");
    rd(ADDR_STATUS, 32'h1,         "simul_status");
    rd(ADDR_DEV0,   32'h7A7A_0001, "simul_reread");
    rd(ADDR_STATUS, 32'h0,         "simul_clear");

    // Unmapped read, then idle cycles while both buses change.
    rd(16'h0003, 32'h0, "unmapped");
    a0 = $urandom() | 32'h1;
    if (a0 == d0) a0 = ~a0 | 32'h1;
    a1 = $urandom();
    if (a1 == d1) a1 = ~a1;
    d0 = a0;
    d1 = a1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_hold", value, 32'h0);
    end

    // Address decode table with both devices pending.
    tbl[0] = '{ADDR_STATUS, 32'h3};
    tbl[1] = '{16'h0100,    32'h0};
    tbl[2] = '{16'hFFFF,    32'h0};
    tbl[3] = '{16'h8002,    32'h0};
    tbl[4] = '{ADDR_DEV1,   a1};
    tbl[5] = '{ADDR_STATUS, 32'h1};
    tbl[6] = '{16'h8000,    32'h0};
    tbl[7] = '{16'($urandom_range(3, 16'hFFFF)), 32'h0};
    tbl[8] = '{ADDR_DEV0,   a0};
    tbl[9] = '{ADDR_STATUS, 32'h0};
    for (int i = 0; i < 10; i++) begin
      rd(tbl[i].addr, tbl[i].exp, $sformatf("table%0d", i));
    end

    // Reset in the middle of operation with pend1 and ovr1 set.
    d1 = 32'hCAFE_0001;
    tick(1);
    d1 = 32'hCAFE_0002;
    tick(SS + 1);
    rd(ADDR_DEV0, a0, "pre_reset_data");
    reset = 1'b1;
    tick(1);
    check("mid_reset_value", value, 32'h0);
    reset = 1'b0;
    tick(SS + 2);
    rd(ADDR_STATUS, 32'h0,         "post_reset_status");
    rd(ADDR_DEV1,   32'hCAFE_0002, "post_reset_data");
    rd(ADDR_STATUS, 32'h0,         "post_reset_status2");

    tick(2);
    check("queue_drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
